fp_addsub_pipe: RTL and testbench

FP_ADDSUB_PIPE -- requirements
Module: fp_addsub_pipe

---
 rtl/fp_pkg.sv | 50 +++++
 rtl/fp_lzc.sv | 28 ++
 rtl/fp_addsub_pipe.sv | 237 +++++++++++++++++++++++
 tb/tb_fp_addsub_pipe.sv | 274 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/fp_pkg.sv
// rtl/fp_pkg.sv - shared types, constants and helpers for the floating-point add/sub pipeline
//
// Contents:
//   fp_class_e     operand class after decode (denormals decode as ZERO)
//   fp_unpacked_t  sign plus class of a decoded operand
//   FLAG_*         bit positions inside the {invalid, overflow, inexact} flag vector
//   fp_classify    class from exponent/mantissa summary bits (width independent)
//   fp_canon_nan   canonical quiet NaN for any exponent/mantissa width
//   fp_sig_w       working significand width: carry + hidden + mantissa + G/R/S
package fp_pkg;

    localparam int FP_MAX_W = 128;

    typedef enum logic [2:0] {ZERO, NORM, INF, QNAN, SNAN} fp_class_e;

    typedef struct packed {
        logic      sign;
        fp_class_e cls;
    } fp_unpacked_t;

    localparam int FLAG_INEXACT  = 0;
    localparam int FLAG_OVERFLOW = 1;
    localparam int FLAG_INVALID  = 2;

    function automatic fp_class_e fp_classify(input logic exp_ones, input logic exp_zero,
                                              input logic man_zero, input logic man_msb);
        fp_class_e cls;
        if (exp_zero)       cls = ZERO;
        else if (!exp_ones) cls = NORM;
        else if (man_zero)  cls = INF;
        else if (man_msb)   cls = QNAN;
        else                cls = SNAN;
        return cls;
    endfunction

    // Sign 0, exponent all ones, mantissa MSB set; caller keeps the low 1+exp_w+man_w bits.
    function automatic logic [FP_MAX_W-1:0] fp_canon_nan(input int exp_w, input int man_w);
        logic [FP_MAX_W-1:0] w;
        w = '0;
        for (int i = 0; i < FP_MAX_W; i++) begin
            if (i >= man_w - 1 && i < man_w + exp_w) w[i] = 1'b1;
        end
        return w;
    endfunction

    function automatic int fp_sig_w(input int man_w);
        return man_w + 5;
    endfunction

endpackage

// File: rtl/fp_lzc.sv
// rtl/fp_lzc.sv - combinational leading-zero counter
//
// Ports:
//   data  WIDTH-bit input vector
//   cnt   number of zeros above the most significant set bit (WIDTH when data is zero)
module fp_lzc #(
    parameter int WIDTH = 27
) (
    input  logic [WIDTH-1:0]         data,
    output logic [$clog2(WIDTH+1)-1:0] cnt
);

    localparam int CW = $clog2(WIDTH + 1);

    logic found;

    always_comb begin
        cnt   = CW'(WIDTH);
        found = 1'b0;
        for (int i = WIDTH - 1; i >= 0; i--) begin
            if (!found && data[i]) begin
                cnt   = CW'(WIDTH - 1 - i);
                found = 1'b1;
            end
        end
    end

endmodule

// File: rtl/fp_addsub_pipe.sv
// rtl/fp_addsub_pipe.sv - 3-stage IEEE-754-style adder/subtractor, RNE, DAZ/FTZ
//
// Ports:
//   clk, rstn            clock, asynchronous active-low reset
//   in_valid, in_ready   operand handshake; in_ready is the global pipeline enable
//   op                   0 = a+b, 1 = a-b
//   a, b                 operands, W = 1+EXP_W+MAN_W bits
//   out_valid, out_ready result handshake
//   result, flags        rounded result and {invalid, overflow, inexact}
module fp_addsub_pipe
    import fp_pkg::*;
#(
    parameter int EXP_W = 8,
    parameter int MAN_W = 23,
    localparam int W    = 1 + EXP_W + MAN_W
) (
    input  logic         clk,
    input  logic         rstn,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic         op,
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [W-1:0] result,
    output logic [2:0]   flags
);

    localparam int AW  = fp_sig_w(MAN_W);   // carry, hidden, mantissa, G, R, S
    localparam int NW  = AW - 1;            // significand without the carry bit
    localparam int LZW = $clog2(NW + 1);
    localparam int XW  = ((EXP_W > LZW) ? EXP_W : LZW) + 2;
    localparam logic [EXP_W-1:0]    SHIFT_MAX  = EXP_W'(MAN_W + 3);
    localparam logic [W-2:0]        INF_MAG    = {{EXP_W{1'b1}}, {MAN_W{1'b0}}};
    localparam logic [FP_MAX_W-1:0] NAN_FULL   = fp_canon_nan(EXP_W, MAN_W);
    localparam logic [W-1:0]        CANON_NAN  = NAN_FULL[W-1:0];
    localparam logic [XW-1:0]       EXP_ONES_X = {{(XW-EXP_W){1'b0}}, {EXP_W{1'b1}}};
    localparam logic [XW-1:0]       ONE_X      = {{(XW-1){1'b0}}, 1'b1};

    logic en;
    assign en       = !out_valid || out_ready;
    assign in_ready = en;

    // ---------------- S1: unpack, classify, swap, align ----------------
    logic [EXP_W-1:0]   a_exp, b_exp, exp_diff;
    logic [MAN_W-1:0]   a_man, b_man;
    logic [W-2:0]       a_mag, b_mag, l_mag, s_mag;
    logic [AW-1:0]      sig_l, sig_s, s_shift, aligned;
    logic               l_sign, eff_sub, lost, sp;
    logic [W-1:0]       sp_res;
    logic [2:0]         sp_flags;
    fp_unpacked_t       ua, ub;

    assign a_exp = a[W-2:MAN_W];
    assign b_exp = b[W-2:MAN_W];
    assign a_man = a[MAN_W-1:0];
    assign b_man = b[MAN_W-1:0];

    always_comb begin
        ua.sign = a[W-1];
        ua.cls  = fp_classify(&a_exp, a_exp == '0, a_man == '0, a_man[MAN_W-1]);
        ub.sign = b[W-1] ^ op;
        ub.cls  = fp_classify(&b_exp, b_exp == '0, b_man == '0, b_man[MAN_W-1]);
    end

    // Denormal inputs read as zero, so their magnitude is forced to all zeros.
    assign a_mag   = (ua.cls == ZERO) ? '0 : {a_exp, a_man};
    assign b_mag   = (ub.cls == ZERO) ? '0 : {b_exp, b_man};
    assign eff_sub = ua.sign ^ ub.sign;

    always_comb begin
        if (a_mag >= b_mag) begin
            l_mag  = a_mag;
            s_mag  = b_mag;
            l_sign = ua.sign;
        end else begin
            l_mag  = b_mag;
            s_mag  = a_mag;
            l_sign = ub.sign;
        end
    end

    assign exp_diff = l_mag[W-2:MAN_W] - s_mag[W-2:MAN_W];
    assign sig_l    = {1'b0, |l_mag[W-2:MAN_W], l_mag[MAN_W-1:0], 3'b000};
    assign sig_s    = {1'b0, |s_mag[W-2:MAN_W], s_mag[MAN_W-1:0], 3'b000};
    assign s_shift  = sig_s >> exp_diff;
    assign lost     = |(sig_s & ~({AW{1'b1}} << exp_diff));
    assign aligned  = (exp_diff >= SHIFT_MAX) ? {{(AW-1){1'b0}}, |sig_s}
                                              : {s_shift[AW-1:1], s_shift[0] | lost};

    // Infinity/NaN operands bypass the datapath with a ready-made result.
    always_comb begin
        sp       = 1'b0;
        sp_res   = '0;
        sp_flags = '0;
        if (ua.cls inside {QNAN, SNAN} || ub.cls inside {QNAN, SNAN}) begin
            sp                     = 1'b1;
            sp_res                 = CANON_NAN;
            sp_flags[FLAG_INVALID] = (ua.cls == SNAN) || (ub.cls == SNAN);
        end else if (ua.cls == INF && ub.cls == INF) begin
            sp = 1'b1;
            if (eff_sub) begin
                sp_res                 = CANON_NAN;
                sp_flags[FLAG_INVALID] = 1'b1;
            end else begin
                sp_res = {ua.sign, INF_MAG};
            end
        end else if (ua.cls == INF) begin
            sp     = 1'b1;
            sp_res = {ua.sign, INF_MAG};
        end else if (ub.cls == INF) begin
            sp     = 1'b1;
            sp_res = {ub.sign, INF_MAG};
        end
    end

    logic             s1_valid, s1_sp, s1_sign, s1_sub;
    logic [W-1:0]     s1_sp_res;
    logic [2:0]       s1_sp_flags;
    logic [EXP_W-1:0] s1_exp;
    logic [AW-1:0]    s1_sig_l, s1_sig_s;

    // ---------------- S2: add/subtract, leading-zero count ----------------
    logic [AW-1:0]  sum;
    logic [LZW-1:0] sum_lzc;

    // Operands are magnitude ordered, so the difference is never negative.
    assign sum = s1_sub ? (s1_sig_l - s1_sig_s) : (s1_sig_l + s1_sig_s);

    fp_lzc #(.WIDTH(NW)) u_lzc (
        .data (sum[NW-1:0]),
        .cnt  (sum_lzc)
    );

    logic             s2_valid, s2_sp, s2_sign, s2_sub;
    logic [W-1:0]     s2_sp_res;
    logic [2:0]       s2_sp_flags;
    logic [EXP_W-1:0] s2_exp;
    logic [AW-1:0]    s2_sum;
    logic [LZW-1:0]   s2_lzc;

    // ---------------- S3: normalise, round, pack ----------------
    logic             carry, sum_zero, underflow, rnd_up, rnd_ovf, zero_sign;
    logic [XW-1:0]    exp_x, lzc_x, exp_n, exp_f;
    logic [NW-1:0]    norm;
    logic [MAN_W+1:0] rounded;
    logic [MAN_W-1:0] man_out;
    logic [W-1:0]     res_n;
    logic [2:0]       flags_n;

    assign carry     = s2_sum[AW-1];
    assign sum_zero  = (s2_sum == '0);
    assign exp_x     = {{(XW-EXP_W){1'b0}}, s2_exp};
    assign lzc_x     = {{(XW-LZW){1'b0}}, s2_lzc};
    assign underflow = !carry && (lzc_x >= exp_x);
    assign exp_n     = carry ? (exp_x + ONE_X) : (exp_x - lzc_x);
    assign norm      = carry ? {s2_sum[AW-1:2], |s2_sum[1:0]} : (s2_sum[NW-1:0] << s2_lzc);
    assign rnd_up    = norm[2] & (norm[1] | norm[0] | norm[3]);
    assign rounded   = {1'b0, norm[NW-1:3]} + {{(MAN_W+1){1'b0}}, rnd_up};
    assign rnd_ovf   = rounded[MAN_W+1];
    assign man_out   = rnd_ovf ? rounded[MAN_W:1] : rounded[MAN_W-1:0];
    assign exp_f     = exp_n + {{(XW-1){1'b0}}, rnd_ovf};
    // An exact-zero difference is +0; a zero sum keeps the common operand sign.
    assign zero_sign = s2_sub ? 1'b0 : s2_sign;

    always_comb begin
        res_n   = '0;
        flags_n = '0;
        if (s2_sp) begin
            res_n   = s2_sp_res;
            flags_n = s2_sp_flags;
        end else if (sum_zero) begin
            res_n = {zero_sign, {(W-1){1'b0}}};
        end else if (underflow) begin
            res_n                 = {s2_sign, {(W-1){1'b0}}};
            flags_n[FLAG_INEXACT] = 1'b1;
        end else if (exp_f >= EXP_ONES_X) begin
            res_n                  = {s2_sign, INF_MAG};
            flags_n[FLAG_OVERFLOW] = 1'b1;
            flags_n[FLAG_INEXACT]  = 1'b1;
        end else begin
            res_n                 = {s2_sign, exp_f[EXP_W-1:0], man_out};
            flags_n[FLAG_INEXACT] = |norm[2:0];
        end
    end

    // ---------------- pipeline registers ----------------
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            s1_valid    <= 1'b0;
            s1_sp       <= 1'b0;
            s1_sp_res   <= '0;
            s1_sp_flags <= '0;
            s1_sign     <= 1'b0;
            s1_sub      <= 1'b0;
            s1_exp      <= '0;
            s1_sig_l    <= '0;
            s1_sig_s    <= '0;
            s2_valid    <= 1'b0;
            s2_sp       <= 1'b0;
            s2_sp_res   <= '0;
            s2_sp_flags <= '0;
            s2_sign     <= 1'b0;
            s2_sub      <= 1'b0;
            s2_exp      <= '0;
            s2_sum      <= '0;
            s2_lzc      <= '0;
            out_valid   <= 1'b0;
            result      <= '0;
            flags       <= '0;
        end else if (en) begin
            s1_valid    <= in_valid;
            s1_sp       <= sp;
            s1_sp_res   <= sp_res;
            s1_sp_flags <= sp_flags;
            s1_sign     <= l_sign;
            s1_sub      <= eff_sub;
            s1_exp      <= l_mag[W-2:MAN_W];
            s1_sig_l    <= sig_l;
            s1_sig_s    <= aligned;
            s2_valid    <= s1_valid;
            s2_sp       <= s1_sp;
            s2_sp_res   <= s1_sp_res;
            s2_sp_flags <= s1_sp_flags;
            s2_sign     <= s1_sign;
            s2_sub      <= s1_sub;
            s2_exp      <= s1_exp;
            s2_sum      <= sum;
            s2_lzc      <= sum_lzc;
            out_valid   <= s2_valid;
            result      <= res_n;
            flags       <= flags_n;
        end
    end

endmodule

// File: tb/tb_fp_addsub_pipe.sv
// tb/tb_fp_addsub_pipe.sv - scoreboard bench for fp_addsub_pipe (binary32)
module tb_fp_addsub_pipe;

    logic        clk;
    logic        rstn;
    logic        in_valid;
    logic        in_ready;
    logic        op;
    logic [31:0] a;
    logic [31:0] b;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] result;
    logic [2:0]  flags;

    typedef struct {
        logic [31:0] res;
        logic [2:0]  flg;
        int          acc_cyc;
        bit          chk_lat;
        int          id;
    } exp_t;

    exp_t exp_q[$];
    int   checks;
    int   failures;
    int   cyc;
    int   out_seen;
    bit   rnd_ready;
    bit   ready_fixed;

    fp_addsub_pipe #(.EXP_W(8), .MAN_W(23)) dut (
        .clk       (clk),
        .rstn      (rstn),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .op        (op),
        .a         (a),
        .b         (b),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .result    (result),
        .flags     (flags)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        cyc = 0;
        forever begin
            @(posedge clk);
            cyc++;
        end
    end

    // out_ready changes just after each falling edge.
    initial begin
        out_ready = 1'b0;
        forever begin
            @(negedge clk);
            #1;
            out_ready = rnd_ready ? 1'($urandom_range(0, 1)) : ready_fixed;
        end
    end

    initial begin
        #300000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s: got %h expected %h", nm, act, req);
        end
    endtask

    // Called at negedge+1; returns at negedge+1 of the cycle after acceptance.
    task automatic send(input logic [31:0] va, input logic [31:0] vb, input logic vop,
                        input logic [31:0] er, input logic [2:0] ef, input bit lat, input int id);
        exp_t e;
        bit   accepted;
        int   waitc;
        accepted = 0;
        waitc    = 0;
        in_valid = 1'b1;
        a        = va;
        b        = vb;
        op       = vop;
        while (!accepted && waitc < 200) begin
            #3;
            if (in_ready) begin
                accepted  = 1;
                e.res     = er;
                e.flg     = ef;
                e.acc_cyc = cyc;
                e.chk_lat = lat;
                e.id      = id;
                exp_q.push_back(e);
            end
            @(negedge clk);
            #1;
            waitc++;
        end
        in_valid = 1'b0;
        if (!accepted) begin
            checks++;
            failures++;
            $display("FAIL accept_timeout vec%0d: in_ready low for %0d cycles, required acceptance", id, waitc);
        end
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < 300) begin
            @(negedge clk);
            #1;
            n++;
        end
        checks++;
        if (exp_q.size() != 0) begin
            failures++;
            $display("FAIL drain_timeout: %0d results outstanding, required 0", exp_q.size());
        end
    endtask

    // Monitor: looks at the handshake just before the rising edge.
    initial begin
        bit          prev_stalled;
        logic [31:0] prev_res;
        logic [2:0]  prev_flg;
        exp_t        e;
        prev_stalled = 0;
        prev_res     = '0;
        prev_flg     = '0;
        forever begin
            @(negedge clk);
            #4;
            if (!rstn) begin
                prev_stalled = 0;
            end else begin
                if (prev_stalled) begin
                    checks++;
                    if (!out_valid || result !== prev_res || flags !== prev_flg) begin
                        failures++;
                        $display("FAIL stall_hold: out_valid=%0b result=%h flags=%b required 1 %h %b",
                                 out_valid, result, flags, prev_res, prev_flg);
                    end
                end
                if (out_valid && out_ready) begin
                    out_seen++;
                    checks++;
                    if (exp_q.size() == 0) begin
                        failures++;
                        $display("FAIL unexpected_output: result=%h flags=%b required no output",
                                 result, flags);
                    end else begin
                        e = exp_q.pop_front();
                        if (result !== e.res || flags !== e.flg) begin
                            failures++;
                            $display("FAIL vec%0d: result=%h flags=%b required %h %b",
                                     e.id, result, flags, e.res, e.flg);
                        end
                        if (e.chk_lat) begin
                            checks++;
                            if (cyc - e.acc_cyc != 3) begin
                                failures++;
                                $display("FAIL latency vec%0d: %0d cycles required 3",
                                         e.id, cyc - e.acc_cyc);
                            end
                        end
                    end
                end
                prev_stalled = out_valid && !out_ready;
                prev_res     = result;
                prev_flg     = flags;
            end
        end
    end

    initial begin
        int seen0;
        checks      = 0;
        failures    = 0;
        out_seen    = 0;
        rnd_ready   = 0;
        ready_fixed = 1;
        rstn        = 1'b0;
        in_valid    = 1'b0;
        op          = 1'b0;
        a           = '0;
        b           = '0;

        repeat (3) @(negedge clk);
        #1;
        chk("reset_out_valid", {31'd0, out_valid}, 32'd0);
        chk("reset_result", result, 32'd0);
        chk("reset_flags", {29'd0, flags}, 32'd0);
        rstn = 1'b1;
        #2;
        chk("in_ready_after_reset", {31'd0, in_ready}, 32'd1);
        @(negedge clk);
        #1;

        // Directed vectors, consumer always ready.
        send(32'h3F800000, 32'h3F800000, 1'b0, 32'h40000000, 3'b000, 1, 1);
        send(32'h3F800000, 32'h3F800000, 1'b1, 32'h00000000, 3'b000, 0, 2);
        send(32'h3F800000, 32'h33800000, 1'b0, 32'h3F800000, 3'b001, 0, 3);
        send(32'h3F800001, 32'h33800000, 1'b0, 32'h3F800002, 3'b001, 0, 4);
        send(32'h7F7FFFFF, 32'h7F7FFFFF, 1'b0, 32'h7F800000, 3'b011, 0, 5);
        send(32'h7F800000, 32'h7F800000, 1'b1, 32'h7FC00000, 3'b100, 0, 6);
        send(32'h00000001, 32'h3F800000, 1'b0, 32'h3F800000, 3'b000, 0, 7);
        send(32'h00800001, 32'h00800000, 1'b1, 32'h00000000, 3'b001, 0, 8);
        send(32'h3F800000, 32'h3FC00000, 1'b0, 32'h40200000, 3'b000, 0, 9);
        drain();

        // Back-to-back pairs with a randomly stalling consumer.
        rnd_ready = 1;
        send(32'h40000000, 32'h3F800000, 1'b0, 32'h40400000, 3'b000, 0, 10);
        send(32'h40400000, 32'h3F800000, 1'b1, 32'h40000000, 3'b000, 0, 11);
        send(32'h3F800000, 32'h40000000, 1'b1, 32'hBF800000, 3'b000, 0, 12);
        send(32'hC0000000, 32'h3F800000, 1'b0, 32'hBF800000, 3'b000, 0, 13);
        send(32'h7F800000, 32'h3F800000, 1'b0, 32'h7F800000, 3'b000, 0, 14);
        send(32'hFF800000, 32'h7F800000, 1'b1, 32'hFF800000, 3'b000, 0, 15);
        send(32'h7FC00000, 32'h3F800000, 1'b0, 32'h7FC00000, 3'b000, 0, 16);
        send(32'h7F800001, 32'h3F800000, 1'b0, 32'h7FC00000, 3'b100, 0, 17);
        send(32'h80000000, 32'h80000000, 1'b0, 32'h80000000, 3'b000, 0, 18);
        send(32'h80000000, 32'h80000000, 1'b1, 32'h00000000, 3'b000, 0, 19);
        drain();
        rnd_ready   = 0;
        ready_fixed = 0;
        @(negedge clk);
        #1;

        // Reset with one result stalled at the output and one still in flight.
        send(32'h3F800000, 32'h3F800000, 1'b0, 32'h40000000, 3'b000, 0, 20);
        send(32'h40000000, 32'h3F800000, 1'b0, 32'h40400000, 3'b000, 0, 21);
        repeat (2) begin
            @(negedge clk);
            #1;
        end
        chk("stalled_before_reset", {31'd0, out_valid}, 32'd1);
        #1;
        rstn = 1'b0;
        #1;
        chk("midop_reset_out_valid", {31'd0, out_valid}, 32'd0);
        chk("midop_reset_result", result, 32'd0);
        chk("midop_reset_flags", {29'd0, flags}, 32'd0);
        exp_q.delete();
        ready_fixed = 1;
        repeat (2) @(negedge clk);
        #1;
        seen0 = out_seen;
        rstn  = 1'b1;
        #2;
        chk("in_ready_after_midop_reset", {31'd0, in_ready}, 32'd1);
        repeat (8) @(negedge clk);
        #1;
        chk("no_stale_output", out_seen, seen0);

        send(32'h3F800000, 32'hBF800000, 1'b0, 32'h00000000, 3'b000, 1, 22);
        drain();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
